// File: rtl/prefetch_redirect_ctrl.sv
// Sequences a CS:IP redirect into the prefetcher: stall, drain (with timeout abort), flush, load.
// Optional statistics counters are built when REDIRECT_STATS_EN is defined.
module prefetch_redirect_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter logic [15:0] RESET_CS      = 16'hffff,
  parameter logic [15:0] RESET_IP      = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update_in,
  input  logic [15:0] cs_in,
  input  logic [15:0] ip_in,
  input  logic        fetch_busy,
  input  logic        fetch_ack,
  output logic        fetch_stall,
  output logic        fetch_abort,
  output logic        fifo_flush,
  output logic        load_addr,
  output logic [15:0] fetch_cs,
  output logic [15:0] fetch_ip,
  output logic [19:0] fetch_addr,
  output logic        busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [15:0] redirect_count,
  output logic [15:0] merge_count,
  output logic [15:0] abort_count
`endif
);

  localparam int unsigned CW = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush, StLoad} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cs_q, ip_q;
  logic [CW-1:0] drain_cnt_q;
  logic          load_pend_q;
  logic          drain_last;

  assign drain_last  = (state_q == StDrain) && (drain_cnt_q == CntLast);
  // An ack arriving on the timeout cycle completes the access normally.
  assign fetch_abort = drain_last && fetch_busy && !fetch_ack;
  // A new request landing in LOAD makes the captured address stale, so hold the load back.
  assign load_addr   = load_pend_q && !update_in;
  assign fetch_stall = busy;
  assign fetch_cs    = cs_q;
  assign fetch_ip    = ip_q;
  assign fetch_addr  = {cs_q, 4'h0} + {4'h0, ip_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (update_in) state_d = fetch_busy ? StDrain : StFlush;
      StDrain: if (fetch_ack || !fetch_busy || drain_last) state_d = StFlush;
      StFlush: state_d = StLoad;
      StLoad:  state_d = update_in ? StFlush : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cs_q        <= RESET_CS;
      ip_q        <= RESET_IP;
      drain_cnt_q <= '0;
      busy        <= 1'b0;
      fifo_flush  <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (update_in) begin
        cs_q <= cs_in;
        ip_q <= ip_in;
      end
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
      busy        <= (state_d != StIdle);
      fifo_flush  <= (state_d == StFlush);
      load_pend_q <= (state_d == StLoad);
    end
  end

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_count <= '0;
      merge_count    <= '0;
      abort_count    <= '0;
    end else begin
      if (load_addr && redirect_count != 16'hffff) redirect_count <= redirect_count + 16'd1;
      if (update_in && busy && merge_count != 16'hffff) merge_count <= merge_count + 16'd1;
      if (fetch_abort && abort_count != 16'hffff) abort_count <= abort_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_redirect_ctrl.sv
// Bench for prefetch_redirect_ctrl: vector table, directed corner sequences, random vs model.
module tb_prefetch_redirect_ctrl;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        update_in, fetch_busy, fetch_ack;
  logic [15:0] cs_in, ip_in;
  logic        fetch_stall, fetch_abort, fifo_flush, load_addr, busy;
  logic [15:0] fetch_cs, fetch_ip;
  logic [19:0] fetch_addr;
`ifdef REDIRECT_STATS_EN
  logic [15:0] redirect_count, merge_count, abort_count;
`endif

  always #5 clk = ~clk;

  prefetch_redirect_ctrl #(
    .DRAIN_TIMEOUT(TO),
    .RESET_CS     (16'hffff),
    .RESET_IP     (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .update_in  (update_in),
    .cs_in      (cs_in),
    .ip_in      (ip_in),
    .fetch_busy (fetch_busy),
    .fetch_ack  (fetch_ack),
    .fetch_stall(fetch_stall),
    .fetch_abort(fetch_abort),
    .fifo_flush (fifo_flush),
    .load_addr  (load_addr),
    .fetch_cs   (fetch_cs),
    .fetch_ip   (fetch_ip),
    .fetch_addr (fetch_addr),
    .busy       (busy)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_count(redirect_count),
    .merge_count   (merge_count),
    .abort_count   (abort_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: cycles left before a forced abort (-1 = not draining) and
  // number of stall cycles still owed after the drain (2 = flush next, 1 = load next).
  int          m_left;
  int          m_tail;
  logic [15:0] m_cs, m_ip;
  int          m_redir, m_merge, m_abort;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = -1; m_tail = 0; m_cs = 16'hffff; m_ip = 16'h0000;
    m_redir = 0; m_merge = 0; m_abort = 0;
  endtask

  function automatic logic [56:0] model_out(input logic upd, input logic fb, input logic ack);
    logic mb, ab, fl, ld;
    int   a;
    mb = (m_left >= 0) || (m_tail > 0);
    ab = (m_left == 1) && fb && !ack;
    fl = (m_tail == 2);
    ld = (m_tail == 1) && !upd;
    a  = (int'(m_cs) * 16 + int'(m_ip)) % 32'h100000;
    return {mb, ab, fl, ld, mb, m_cs, m_ip, a[19:0]};
  endfunction

  task automatic model_step(input logic upd, input logic [15:0] cs, input logic [15:0] ip,
                            input logic fb, input logic ack);
    logic [56:0] o;
    o = model_out(upd, fb, ack);
    if (o[55]) m_abort++;
    if (o[53]) m_redir++;
    if (upd && o[52]) m_merge++;
    if (upd) begin m_cs = cs; m_ip = ip; end
    if (m_left >= 0) begin
      if (ack || !fb || m_left == 1) begin m_left = -1; m_tail = 2; end
      else m_left--;
    end else if (m_tail == 2) m_tail = 1;
    else if (m_tail == 1) m_tail = upd ? 2 : 0;
    else if (upd) begin
      if (fb) m_left = TO;
      else m_tail = 2;
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare against the model, advance it.
  task automatic step(input logic upd, input logic [15:0] cs, input logic [15:0] ip,
                      input logic fb, input logic ack);
    @(negedge clk);
    update_in = upd; cs_in = cs; ip_in = ip; fetch_busy = fb; fetch_ack = ack;
    #1;
    chk("model", {7'd0, fetch_stall, fetch_abort, fifo_flush, load_addr, busy,
                  fetch_cs, fetch_ip, fetch_addr}, {7'd0, model_out(upd, fb, ack)});
`ifdef REDIRECT_STATS_EN
    chk("stats", {16'd0, redirect_count, merge_count, abort_count},
        {16'd0, m_redir[15:0], m_merge[15:0], m_abort[15:0]});
`endif
    model_step(upd, cs, ip, fb, ack);
  endtask

  typedef struct {
    logic        upd;
    logic [15:0] cs;
    logic [15:0] ip;
    logic        fb;
    logic        ack;
    logic [4:0]  flags; // {stall, abort, flush, load, busy}
    logic [19:0] addr;
  } vec_t;

  vec_t tbl[10];
  logic fb_r;

  initial begin
    // Idle redirect, then a drained redirect acked on the third drain cycle.
    tbl[0] = '{1'b1, 16'h1234, 16'h0010, 1'b0, 1'b0, 5'b00000, 20'hffff0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'b10101, 20'h12350};
    tbl[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'b10011, 20'h12350};
    tbl[3] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'b00000, 20'h12350};
    tbl[4] = '{1'b1, 16'h0100, 16'h0005, 1'b1, 1'b0, 5'b00000, 20'h12350};
    tbl[5] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'b10001, 20'h01005};
    tbl[6] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'b10001, 20'h01005};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 5'b10001, 20'h01005};
    tbl[8] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'b10101, 20'h01005};
    tbl[9] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'b10011, 20'h01005};

    update_in = 0; cs_in = 0; ip_in = 0; fetch_busy = 0; fetch_ack = 0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_outs", {59'd0, fetch_stall, fetch_abort, fifo_flush, load_addr, busy}, 64'd0);
    chk("reset_addr", {44'd0, fetch_addr}, 64'hffff0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].upd, tbl[i].cs, tbl[i].ip, tbl[i].fb, tbl[i].ack);
      chk($sformatf("vec%0d", i),
          {39'd0, fetch_stall, fetch_abort, fifo_flush, load_addr, busy, fetch_addr},
          {39'd0, tbl[i].flags, tbl[i].addr});
    end
    step(0, 0, 0, 0, 0);

    // Timeout: busy never drops, abort on the 16th cycle only.
    step(1, 16'h0abc, 16'h0001, 1, 0);
    for (int i = 1; i <= 19; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("to_abort%0d", i), {63'd0, fetch_abort}, {63'd0, (i == 16)});
      chk($sformatf("to_flush%0d", i), {63'd0, fifo_flush}, {63'd0, (i == 17)});
      chk($sformatf("to_load%0d", i), {63'd0, load_addr}, {63'd0, (i == 18)});
    end

    // Ack coincident with timeout: ack wins.
    step(1, 16'h0001, 16'h0001, 1, 0);
    for (int i = 1; i <= 15; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("ack_wins", {63'd0, fetch_abort}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("ack_flush", {63'd0, fifo_flush}, 64'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("idle_ack", {63'd0, busy}, 64'd0);

    // Address wrap past 20 bits.
    step(1, 16'hffff, 16'h0010, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wrap_load", {63'd0, load_addr}, 64'd1);
    chk("wrap_addr", {44'd0, fetch_addr}, 64'h00000);

    // Merge landing on the LOAD cycle.
    step(1, 16'h1111, 16'h0000, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 16'h2000, 16'h0000, 0, 0);
    chk("merge_noload", {63'd0, load_addr}, 64'd0);
    step(0, 0, 0, 0, 0);
    chk("merge_reflush", {63'd0, fifo_flush}, 64'd1);
    step(0, 0, 0, 0, 0);
    chk("merge_load", {63'd0, load_addr}, 64'd1);
    chk("merge_addr", {44'd0, fetch_addr}, 64'h20000);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset while draining.
    step(1, 16'h3000, 16'h0004, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("drain_busy", {63'd0, busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_outs", {59'd0, fetch_stall, fetch_abort, fifo_flush, load_addr, busy}, 64'd0);
    chk("arst_addr", {44'd0, fetch_addr}, 64'hffff0);
`ifdef REDIRECT_STATS_EN
    chk("arst_stats", {16'd0, redirect_count, merge_count, abort_count}, 64'd0);
`endif
    model_reset();
    #1 reset = 1'b0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Random traffic against the model.
    fb_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) fb_r = ~fb_r;
      step(($urandom_range(0, 4) == 0), 16'($urandom), 16'($urandom), fb_r,
           fb_r && ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
